// File: rtl/scarv_cop_aes_pkg.sv
// Shared AES S-box definitions: FSM states, affine constants, field polynomial
// and the GF(2^8) / affine helper functions used by the byte lanes.
package scarv_cop_aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] AFF_FWD = 8'h63;
  localparam logic [7:0] AFF_INV = 8'h05;
  localparam logic [8:0] POLY    = 9'h11B;

  function automatic logic [7:0] rotl8(
    input logic [7:0] b,
    input int unsigned k
  );
    logic [15:0] t;
    t = {b, b} << k;
    return t[15:8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? POLY[7:0] : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8); a = 0 maps to 0 naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] aff_fwd(input logic [7:0] b);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2)
             ^ rotl8(b, 3) ^ rotl8(b, 4) ^ AFF_FWD;
  endfunction

  function automatic logic [7:0] aff_inv(input logic [7:0] b);
    return rotl8(b, 1) ^ rotl8(b, 3)
         ^ rotl8(b, 6) ^ AFF_INV;
  endfunction

endpackage

// File: rtl/scarv_cop_aes_sbox_lane.sv
// One combinational AES byte S-box, forward or inverse.
// Ports: in_i byte in, inv_i selects inverse, out_o substituted byte.
module scarv_cop_aes_sbox_lane
  import scarv_cop_aes_pkg::*;
(
  input  logic [7:0] in_i,
  input  logic       inv_i,
  output logic [7:0] out_o
);

  logic [7:0] pre;
  logic [7:0] inv_b;

  // One shared field inverter: affine before it (inverse) or after (forward).
  assign pre   = inv_i ? aff_inv(in_i) : in_i;
  assign inv_b = gf_inv(pre);
  assign out_o = inv_i ? inv_b : aff_fwd(inv_b);

endmodule

// File: rtl/scarv_cop_aes_sbox_seq.sv
// Sequential AES (Inv)SubBytes over a word, LANES bytes per cycle.
// Ports: in_* request handshake/operand, out_* result handshake/word.
// Option SCARV_COP_AES_SBOX_ROTWORD_EN adds in_rot (SubWord(RotWord(x))).
module scarv_cop_aes_sbox_seq
  import scarv_cop_aes_pkg::*;
#(
  parameter int WORD_BYTES = 4,
  parameter int LANES      = 1
) (
  input  logic                    g_clk,
  input  logic                    g_reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_inv,
  input  logic [8*WORD_BYTES-1:0] in_data,
`ifdef SCARV_COP_AES_SBOX_ROTWORD_EN
  input  logic                    in_rot,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*WORD_BYTES-1:0] out_data
);

  localparam int W    = 8 * WORD_BYTES;
  localparam int NGRP = WORD_BYTES / LANES;
  localparam int CW   = (NGRP > 1) ? $clog2(NGRP) : 1;

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   op_q;
  logic [W-1:0]   op_d;
  logic [W-1:0]   res_q;
  logic [W-1:0]   res_d;
  logic           inv_q;
  logic           in_ready_q;
  logic           out_valid_q;
  logic           last;
  logic [7:0]     lane_in  [LANES];
  logic [7:0]     lane_out [LANES];

`ifdef SCARV_COP_AES_SBOX_ROTWORD_EN
  // Byte i takes byte i+1; rotation is a forward-only operation.
  assign op_d = (in_rot && !in_inv)
              ? ((in_data >> 8) | (in_data << (W - 8)))
              : in_data;
`else
  assign op_d = in_data;
`endif

  assign last = (cnt_q == CW'(NGRP - 1));

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_in[l] = op_q[8*(int'(cnt_q)*LANES + l) +: 8];
    scarv_cop_aes_sbox_lane u_lane (
      .in_i  (lane_in[l]),
      .inv_i (inv_q),
      .out_o (lane_out[l])
    );
  end

  always_comb begin
    res_d = res_q;
    for (int l = 0; l < LANES; l++) begin
      res_d[8*(int'(cnt_q)*LANES + l) +: 8] = lane_out[l];
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      res_q       <= '0;
      inv_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            op_q       <= op_d;
            inv_q      <= in_inv;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          res_q <= res_d;
          if (last) begin
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = res_q;

endmodule
